// File: rtl/pf_index_sequencer.sv
// pf_index_sequencer: phase-factor index sequencer for the modulated sliding DFT.
// For each accepted sample n it sweeps a run of bins k and emits idx = (k*n) mod N_MAX
// once per handshake beat. Indices are built incrementally with adders only: base tracks
// k_start*n across samples, and each beat adds n to the running index.
// Optional feature: define PFSEQ_INVERSE_EN to add i_inverse (conjugate rotation output).
module pf_index_sequencer #(
  parameter int unsigned N_MAX     = 1024,
  parameter int unsigned LOG_N_MAX = $clog2(N_MAX)
) (
  input  logic                 i_sys_clk,
  input  logic                 i_sys_rst_n,
  input  logic                 i_sample_valid,
  output logic                 o_sample_ready,
  input  logic                 i_resync,
  input  logic [LOG_N_MAX-1:0] i_k_start,
  input  logic [LOG_N_MAX:0]   i_num_bins,
`ifdef PFSEQ_INVERSE_EN
  input  logic                 i_inverse,
`endif
  input  logic                 i_ready,
  output logic                 o_valid,
  output logic [LOG_N_MAX-1:0] o_index,
  output logic [1:0]           o_quadrant,
  output logic [LOG_N_MAX-1:0] o_bin,
  output logic                 o_last,
  output logic                 o_done,
  output logic [LOG_N_MAX-1:0] o_n
);

  localparam logic [LOG_N_MAX-1:0] ONE     = 1;
  localparam logic [LOG_N_MAX:0]   ONE_EXT = 1;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DONE
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [LOG_N_MAX-1:0] n_q;
  logic [LOG_N_MAX-1:0] base_q;
  logic [LOG_N_MAX-1:0] acc_q;
  logic [LOG_N_MAX-1:0] bin_q;
  logic [LOG_N_MAX-1:0] cnt_q;
  logic [LOG_N_MAX-1:0] k_start_q;
  logic [LOG_N_MAX-1:0] emit_index;
  logic                 accept;
  logic                 beat;
  logic                 last;
`ifdef PFSEQ_INVERSE_EN
  logic                 inverse_q;
`endif

  assign accept = (state == IDLE) && i_sample_valid;
  assign beat   = (state == SWEEP) && i_ready;
  assign last   = (cnt_q == '0);

  // State register.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and handshake/status outputs.
  always_comb begin
    state_next     = state;
    o_sample_ready = 1'b0;
    o_valid        = 1'b0;
    o_last         = 1'b0;
    o_done         = 1'b0;
    case (state)
      IDLE: begin
        o_sample_ready = 1'b1;
        if (accept) begin
          state_next = (i_num_bins == '0) ? DONE : SWEEP;
        end
      end
      SWEEP: begin
        o_valid = 1'b1;
        o_last  = last;
        if (beat && last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        o_done     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Sample counter, base accumulator and per-beat index/bin/count datapath.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      n_q       <= '0;
      base_q    <= '0;
      acc_q     <= '0;
      bin_q     <= '0;
      cnt_q     <= '0;
      k_start_q <= '0;
`ifdef PFSEQ_INVERSE_EN
      inverse_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (i_resync) begin
            n_q    <= '0;
            base_q <= '0;
          end
          if (accept) begin
            k_start_q <= i_k_start;
            // A coincident resync means this sample already runs at n=0, base=0.
            acc_q     <= i_resync ? '0 : base_q;
            bin_q     <= i_k_start;
            cnt_q     <= LOG_N_MAX'(i_num_bins - ONE_EXT);
`ifdef PFSEQ_INVERSE_EN
            inverse_q <= i_inverse;
`endif
          end
        end
        SWEEP: begin
          if (beat && !last) begin
            acc_q <= acc_q + n_q;
            bin_q <= bin_q + ONE;
            cnt_q <= cnt_q - ONE;
          end
        end
        DONE: begin
          n_q    <= n_q + ONE;
          base_q <= base_q + k_start_q;
        end
        default: ;
      endcase
    end
  end

  // Output index, optionally conjugated; the accumulator itself always runs forward.
  always_comb begin
    emit_index = acc_q;
`ifdef PFSEQ_INVERSE_EN
    if (inverse_q) begin
      emit_index = '0 - acc_q;
    end
`endif
  end

  assign o_index    = emit_index;
  assign o_quadrant = emit_index[LOG_N_MAX-1:LOG_N_MAX-2];
  assign o_bin      = bin_q;
  assign o_n        = n_q;

endmodule

// File: tb/tb_pf_index_sequencer.sv
// Testbench for pf_index_sequencer at N_MAX=16: randomized sweeps checked against
// idx = (k*n) mod N computed directly from the bin and sample number.
module tb_pf_index_sequencer;

  localparam int unsigned N    = 16;
  localparam int unsigned W    = 4;
  localparam int unsigned NONE = 99;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_sample_valid;
  logic         o_sample_ready;
  logic         i_resync;
  logic [W-1:0] i_k_start;
  logic [W:0]   i_num_bins;
`ifdef PFSEQ_INVERSE_EN
  logic         i_inverse;
`endif
  logic         i_ready;
  logic         o_valid;
  logic [W-1:0] o_index;
  logic [1:0]   o_quadrant;
  logic [W-1:0] o_bin;
  logic         o_last;
  logic         o_done;
  logic [W-1:0] o_n;

  pf_index_sequencer #(.N_MAX(N), .LOG_N_MAX(W)) dut (
    .i_sys_clk      (clk),
    .i_sys_rst_n    (rst_n),
    .i_sample_valid (i_sample_valid),
    .o_sample_ready (o_sample_ready),
    .i_resync       (i_resync),
    .i_k_start      (i_k_start),
    .i_num_bins     (i_num_bins),
`ifdef PFSEQ_INVERSE_EN
    .i_inverse      (i_inverse),
`endif
    .i_ready        (i_ready),
    .o_valid        (o_valid),
    .o_index        (o_index),
    .o_quadrant     (o_quadrant),
    .o_bin          (o_bin),
    .o_last         (o_last),
    .o_done         (o_done),
    .o_n            (o_n)
  );

  always #5 clk = ~clk;

  int unsigned check_count = 0;
  int unsigned pass_count  = 0;
  int unsigned model_n     = 0;
  bit          rand_ready  = 1'b0;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    check_count++;
    if (got == exp) pass_count++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int unsigned ref_index(input int unsigned k, input int unsigned n, input bit inv);
    int unsigned idx;
    idx = (k * n) % N;
    return inv ? (N - idx) % N : idx;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(o_valid), 0);
    check({tag, "_index"}, 32'(o_index), 0);
    check({tag, "_bin"},   32'(o_bin), 0);
    check({tag, "_quad"},  32'(o_quadrant), 0);
    check({tag, "_last"},  32'(o_last), 0);
    check({tag, "_done"},  32'(o_done), 0);
    check({tag, "_n"},     32'(o_n), 0);
    check({tag, "_ready"}, 32'(o_sample_ready), 1);
  endtask

  task automatic drive_idle();
    i_sample_valid = 1'b0;
    i_resync       = 1'b0;
`ifdef PFSEQ_INVERSE_EN
    i_inverse      = 1'b0;
`endif
  endtask

  // resync_mode: 0 none, 1 with the accept, 2 a separate idle cycle before it.
  task automatic run_sample(input int unsigned ks, input int unsigned nb,
                            input int unsigned resync_mode, input bit inv,
                            input int unsigned abort_at);
    int unsigned beats;
    int unsigned cycles;
    int unsigned k;
    int unsigned exp_idx;
    beats  = 0;
    cycles = 0;
    while (!o_sample_ready && cycles < 50) begin
      @(negedge clk);
      cycles++;
    end
    check("sample_ready", 32'(o_sample_ready), 1);
    if (resync_mode == 2) begin
      i_resync = 1'b1;
      @(negedge clk);
      i_resync = 1'b0;
      model_n  = 0;
      check("resync_n", 32'(o_n), 0);
    end
    check("n_idle", 32'(o_n), model_n);
    i_sample_valid = 1'b1;
    i_k_start      = W'(ks);
    i_num_bins     = (W+1)'(nb);
    i_resync       = (resync_mode == 1);
`ifdef PFSEQ_INVERSE_EN
    i_inverse      = inv;
`endif
    @(negedge clk);
    if (resync_mode == 1) model_n = 0;
    cycles = 0;
    while (beats < nb && cycles < 200) begin
      // Inputs that must be ignored or were latched at accept get scrambled mid-sweep.
      i_sample_valid = 1'($urandom);
      i_resync       = 1'($urandom);
      i_k_start      = W'($urandom);
      i_num_bins     = (W+1)'($urandom);
`ifdef PFSEQ_INVERSE_EN
      i_inverse      = 1'($urandom);
`endif
      k       = (ks + beats) % N;
      exp_idx = ref_index(k, model_n, inv);
      check("valid",      32'(o_valid), 1);
      check("index",      32'(o_index), exp_idx);
      check("bin",        32'(o_bin), k);
      check("quad",       32'(o_quadrant), exp_idx / (N / 4));
      check("last",       32'(o_last), (beats == nb - 1) ? 1 : 0);
      check("n_sweep",    32'(o_n), model_n);
      check("ready_busy", 32'(o_sample_ready), 0);
      check("done_busy",  32'(o_done), 0);
      if (beats == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        drive_idle();
        rst_n   = 1'b1;
        model_n = 0;
        @(negedge clk);
        check_reset_outputs("post_release");
        return;
      end
      i_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      @(negedge clk);
      if (i_ready) beats++;
      cycles++;
    end
    drive_idle();
    check("done",       32'(o_done), 1);
    check("valid_done", 32'(o_valid), 0);
    check("ready_done", 32'(o_sample_ready), 0);
    @(negedge clk);
    model_n = (model_n + 1) % N;
    check("done_pulse", 32'(o_done), 0);
    check("n_next",     32'(o_n), model_n);
    check("idle_ready", 32'(o_sample_ready), 1);
  endtask

  initial begin
    int unsigned ks;
    bit          inv;
    rst_n      = 1'b0;
    i_ready    = 1'b1;
    i_k_start  = '0;
    i_num_bins = '0;
    drive_idle();
    #22;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // k_start=0, four bins, three samples, downstream always ready.
    run_sample(0, 4, 1, 1'b0, NONE);
    run_sample(0, 4, 0, 1'b0, NONE);
    run_sample(0, 4, 0, 1'b0, NONE);

    // k_start=3, two bins, up to n=5 (indices 15 and 4 on the last one).
    for (int i = 0; i < 6; i++) run_sample(3, 2, (i == 0) ? 1 : 0, 1'b0, NONE);

    // Zero-bin sweeps: n walks through a full wrap.
    for (int i = 0; i < 18; i++) run_sample(3, 0, 0, 1'b0, NONE);
    run_sample(3, 5, 0, 1'b0, NONE);

    // Randomized phases with stalling downstream.
    rand_ready = 1'b1;
    for (int p = 0; p < 8; p++) begin
      ks = $urandom_range(0, N - 1);
      for (int s = 0; s < 5; s++) begin
`ifdef PFSEQ_INVERSE_EN
        inv = 1'($urandom);
`else
        inv = 1'b0;
`endif
        run_sample(ks, $urandom_range(0, N), (s == 0) ? $urandom_range(1, 2) : 0, inv, NONE);
      end
    end

    // Reset in the middle of a sweep, then carry on from n=0.
    run_sample(6, 8, 1, 1'b0, 3);
    run_sample(5, 3, 0, 1'b0, NONE);
    run_sample(5, 3, 0, 1'b0, NONE);

`ifdef PFSEQ_INVERSE_EN
    // Conjugate rotation: n=1 gives 0,15,14,13.
    rand_ready = 1'b0;
    run_sample(0, 4, 1, 1'b1, NONE);
    run_sample(0, 4, 0, 1'b1, NONE);
`endif

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
